instruction_decoder: RTL and testbench



---
 rtl/instruction_decoder.sv | 143 ++++++++++++++
 tb/tb_instruction_decoder.sv | 120 ++++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// instruction_decoder: MIPS-subset control decoder with registered outputs.
// Decode is purely combinational from ins_in; every control bit is flopped
// once, so a decode is visible one cycle after the instruction is sampled.
module instruction_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins_in,
  output logic        jump,
  output logic        branch,
  output logic        mem_to_reg,
  output logic        sign_ext,
  output logic        reg_dest,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic [4:0]  shamt,
  output logic [3:0]  alu_ctrl
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_LUI = 4'b1101;

  typedef struct packed {
    logic       jump;
    logic       branch;
    logic       mem_to_reg;
    logic       sign_ext;
    logic       reg_dest;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [4:0] shamt;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  ctrl_t      ctrl_d, ctrl_q;
  logic [5:0] opcode, funct;

  assign opcode = ins_in[31:26];
  assign funct  = ins_in[5:0];

  // Combinational decode; anything unrecognised falls back to an all-zero bubble
  always_comb begin
    ctrl_d = '0;
    unique case (opcode)
      6'b000000: begin
        ctrl_d.reg_dest  = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.shamt     = ins_in[10:6];
        unique case (funct)
          6'b100000, 6'b100001: ctrl_d.alu_ctrl = ALU_ADD;
          6'b100010, 6'b100011: ctrl_d.alu_ctrl = ALU_SUB;
          6'b100100: ctrl_d.alu_ctrl = ALU_AND;
          6'b100101: ctrl_d.alu_ctrl = ALU_OR;
          6'b100110: ctrl_d.alu_ctrl = ALU_XOR;
          6'b100111: ctrl_d.alu_ctrl = ALU_NOR;
          6'b101010: ctrl_d.alu_ctrl = ALU_SLT;
          6'b000000: ctrl_d.alu_ctrl = ALU_SLL;
          6'b000010: ctrl_d.alu_ctrl = ALU_SRL;
          6'b000011: ctrl_d.alu_ctrl = ALU_SRA;
          6'b001000: begin
            // JR reads rs as the target and writes nothing back
            ctrl_d.reg_dest  = 1'b0;
            ctrl_d.reg_write = 1'b0;
            ctrl_d.jump      = 1'b1;
          end
          default: ctrl_d = '0;
        endcase
      end
      6'b001000, 6'b001001: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.sign_ext  = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = ALU_ADD;
      end
      6'b001010: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.sign_ext  = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = ALU_SLT;
      end
      6'b001100, 6'b001101, 6'b001110: begin
        // Logical immediates are zero-extended
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = (opcode[1:0] == 2'b00) ? ALU_AND :
                           (opcode[1:0] == 2'b01) ? ALU_OR  : ALU_XOR;
      end
      6'b001111: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = ALU_LUI;
      end
      6'b100011: begin
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.sign_ext   = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_ctrl   = ALU_ADD;
      end
      6'b101011: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.sign_ext  = 1'b1;
        ctrl_d.alu_ctrl  = ALU_ADD;
      end
      6'b000100, 6'b000101: begin
        ctrl_d.branch   = 1'b1;
        ctrl_d.sign_ext = 1'b1;
        ctrl_d.alu_ctrl = ALU_SUB;
      end
      6'b000010: ctrl_d.jump = 1'b1;
      default:   ctrl_d = '0;
    endcase
  end

  // Control register; reset wins over any instruction on the same edge
  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= '0;
    else     ctrl_q <= ctrl_d;
  end

  assign jump       = ctrl_q.jump;
  assign branch     = ctrl_q.branch;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign sign_ext   = ctrl_q.sign_ext;
  assign reg_dest   = ctrl_q.reg_dest;
  assign mem_write  = ctrl_q.mem_write;
  assign alu_src    = ctrl_q.alu_src;
  assign reg_write  = ctrl_q.reg_write;
  assign shamt      = ctrl_q.shamt;
  assign alu_ctrl   = ctrl_q.alu_ctrl;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder with hand-computed control vectors.
// Outputs are packed as {jump,branch,mem_to_reg,sign_ext,reg_dest,mem_write,
// alu_src,reg_write,shamt[4:0],alu_ctrl[3:0]} for comparison.
module tb_instruction_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins_in;
  logic        jump, branch, mem_to_reg, sign_ext, reg_dest, mem_write, alu_src, reg_write;
  logic [4:0]  shamt;
  logic [3:0]  alu_ctrl;

  int n_chk = 0;
  int n_pass = 0;

  instruction_decoder dut (
    .clk(clk), .rst(rst), .ins_in(ins_in),
    .jump(jump), .branch(branch), .mem_to_reg(mem_to_reg), .sign_ext(sign_ext),
    .reg_dest(reg_dest), .mem_write(mem_write), .alu_src(alu_src),
    .reg_write(reg_write), .shamt(shamt), .alu_ctrl(alu_ctrl)
  );

  always #5 clk = ~clk;

  // Control-bit masks within the packed 17-bit vector
  localparam logic [16:0] J  = 17'h10000;
  localparam logic [16:0] B  = 17'h08000;
  localparam logic [16:0] MR = 17'h04000;
  localparam logic [16:0] SE = 17'h02000;
  localparam logic [16:0] RD = 17'h01000;
  localparam logic [16:0] MW = 17'h00800;
  localparam logic [16:0] AS = 17'h00400;
  localparam logic [16:0] RW = 17'h00200;

  function automatic logic [16:0] sh(input int s);
    logic [4:0] v;
    v = s[4:0];
    return {8'h00, v, 4'h0};
  endfunction

  function automatic logic [16:0] obs();
    return {jump, branch, mem_to_reg, sign_ext, reg_dest, mem_write, alu_src,
            reg_write, shamt, alu_ctrl};
  endfunction

  task automatic chk(input string tag, input logic [16:0] act, input logic [16:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, act, exp);
  endtask

  // Present ins with rst, clock once, sample 1ns after the edge
  task automatic step(input logic r, input logic [31:0] ins);
    @(negedge clk);
    rst = r;
    ins_in = ins;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       tag;
    logic [31:0] ins;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"lw",    32'h8C220004, MR|AS|SE|RW | 17'h2});
    vecs.push_back('{"sw",    32'hAC220004, MW|AS|SE    | 17'h2});
    vecs.push_back('{"beq",   32'h10221821, B|SE        | 17'h6});
    vecs.push_back('{"bne",   32'h14221821, B|SE        | 17'h6});
    vecs.push_back('{"sll",   32'h00021140, RD|RW | sh(5) | 17'h8});
    vecs.push_back('{"add",   32'h00221820, RD|RW | 17'h2});
    vecs.push_back('{"addu",  32'h00221821, RD|RW | 17'h2});
    vecs.push_back('{"sub",   32'h00221822, RD|RW | 17'h6});
    vecs.push_back('{"and",   32'h00221824, RD|RW | 17'h0});
    vecs.push_back('{"or",    32'h00221825, RD|RW | 17'h1});
    vecs.push_back('{"xor",   32'h00221826, RD|RW | 17'h3});
    vecs.push_back('{"nor",   32'h00221827, RD|RW | 17'hC});
    vecs.push_back('{"slt",   32'h0022182A, RD|RW | 17'h7});
    vecs.push_back('{"srl",   32'h00021142, RD|RW | sh(5) | 17'h9});
    vecs.push_back('{"sra",   32'h000217C3, RD|RW | sh(31) | 17'hA});
    vecs.push_back('{"ori",   32'h34220FFF, AS|RW | 17'h1});
    vecs.push_back('{"andi",  32'h30220FFF, AS|RW | 17'h0});
    vecs.push_back('{"xori",  32'h38220FFF, AS|RW | 17'h3});
    vecs.push_back('{"addi",  32'h20220004, AS|SE|RW | 17'h2});
    vecs.push_back('{"addiu", 32'h24220004, AS|SE|RW | 17'h2});
    vecs.push_back('{"slti",  32'h28220004, AS|SE|RW | 17'h7});
    vecs.push_back('{"lui",   32'h3C011234, AS|RW | 17'hD});
    vecs.push_back('{"j",     32'h08000010, J});
    vecs.push_back('{"illop", 32'hFC000000, 17'h0});
    vecs.push_back('{"badfn", 32'h0000003F, 17'h0});
    vecs.push_back('{"badfn_sh", 32'h000007FF, 17'h0});
    vecs.push_back('{"nop",   32'h00000000, RD|RW | 17'h8});
    vecs.push_back('{"lw2",   32'h8C220004, MR|AS|SE|RW | 17'h2});

    rst = 1'b1;
    ins_in = 32'h8C220004;
    step(1'b1, 32'h8C220004);
    chk("reset0", obs(), 17'h0);
    step(1'b1, 32'h8C220004);
    chk("reset1", obs(), 17'h0);
    step(1'b0, 32'h8C220004);
    chk("rel_lw", obs(), MR|AS|SE|RW | 17'h2);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].ins);
      chk(vecs[i].tag, obs(), vecs[i].exp);
    end

    step(1'b1, 32'h10221821);
    chk("rst_beq", obs(), 17'h0);
    step(1'b0, 32'h10221821);
    chk("rel_beq", obs(), B|SE | 17'h6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
